// File: rtl/pe_result_drain.sv
// -----------------------------------------------------------------------------
// pe_result_drain
//
// Collects accumulated results from one column of N PE cells and serialises
// them onto a single valid/ready stream. Each PE emits a one-cycle
// result-valid pulse. The pulses arrive skewed down the column. Each lane's
// word is parked in a per-lane holding register until the output register is
// free. The array therefore never needs a stall path back into the PEs.
//
// Optional build macro:
//   PE_DRAIN_SAT_EN - when defined, a word with bit OUTWIDTH set is clamped to
//                     2^OUTWIDTH-1 as it enters the output register. Latency
//                     and handshake are the same in both builds.
//
// Ports:
//   clk        in   clock, all logic on the rising edge
//   rst        in   synchronous reset, active-high
//   in_r       in   N*(OUTWIDTH+1) flattened PE results, lane i at
//                   [i*(OUTWIDTH+1) +: OUTWIDTH+1]
//   in_valid   in   N per-lane result-valid pulses
//   out_data   out  OUTWIDTH+1 result word presented downstream
//   out_idx    out  $clog2(N) lane index of out_data
//   out_last   out  high with the Nth word of a frame
//   out_valid  out  out_data/out_idx/out_last are valid
//   out_ready  in   downstream accepts when out_valid && out_ready
//   busy       out  any lane pending or a word held in the output register
//   overflow   out  sticky, a result was lost to a lane collision
// -----------------------------------------------------------------------------
module pe_result_drain #(
    parameter int N        = 4,
    parameter int OUTWIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N*(OUTWIDTH+1)-1:0]     in_r,
    input  logic [N-1:0]                  in_valid,
    output logic [OUTWIDTH:0]             out_data,
    output logic [$clog2(N)-1:0]          out_idx,
    output logic                          out_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy,
    output logic                          overflow
);

    localparam int WW = OUTWIDTH + 1;
    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST_CNT = IW'(N - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    // Word transform applied as a word enters the output register.
    function automatic logic [WW-1:0] drain_word(input logic [WW-1:0] w);
`ifdef PE_DRAIN_SAT_EN
        logic [WW-1:0] r;
        r = w[OUTWIDTH] ? {1'b0, {OUTWIDTH{1'b1}}} : w;
        return r;
`else
        return w;
`endif
    endfunction

    // Registered state
    logic [N-1:0]    pending_r;
    logic [WW-1:0]   hold_r [N];
    logic [WW-1:0]   out_data_r;
    logic [IW-1:0]   out_idx_r;
    logic            out_last_r;
    logic            out_valid_r;
    logic            overflow_r;
    logic            busy_r;
    logic [IW-1:0]   frame_cnt_r;
    state_t          state_r;

    // Combinational control
    logic [IW-1:0]   sel_idx_s;
    logic            load_s;
    logic            accept_s;
    logic [N-1:0]    move_mask_s;
    logic [N-1:0]    capture_s;
    logic [N-1:0]    collide_s;
    logic [N-1:0]    pending_nxt_s;
    logic            out_valid_nxt_s;
    logic [IW-1:0]   cnt_eff_s;
    logic [WW-1:0]   load_word_s;

    // Lowest-index pending lane. Scanning downward lets the lowest set bit win.
    always_comb begin
        sel_idx_s = '0;
        for (int i = N - 1; i >= 0; i--) begin
            sel_idx_s = pending_r[i] ? IW'(i) : sel_idx_s;
        end
    end

    // Handshake, per-lane capture/collision and next-state terms.
    always_comb begin
        load_s      = (!out_valid_r || out_ready) && (|pending_r);
        accept_s    = out_valid_r && out_ready;
        if (load_s) begin
            move_mask_s = N'(1'b1) << sel_idx_s;
        end else begin
            move_mask_s = '0;
        end
        // A lane whose word leaves this cycle may take a new word on the same edge.
        capture_s     = in_valid & (~pending_r | move_mask_s);
        collide_s     = in_valid & pending_r & ~move_mask_s;
        pending_nxt_s = capture_s | (pending_r & ~move_mask_s);
        if (load_s) begin
            out_valid_nxt_s = 1'b1;
        end else if (out_ready) begin
            out_valid_nxt_s = 1'b0;
        end else begin
            out_valid_nxt_s = out_valid_r;
        end
        // Frame position after any acceptance this cycle. The loaded word is
        // the last of its frame when this equals N-1.
        if (accept_s) begin
            cnt_eff_s = (frame_cnt_r == LAST_CNT) ? '0 : IW'(frame_cnt_r + IW'(1'b1));
        end else begin
            cnt_eff_s = frame_cnt_r;
        end
        load_word_s = drain_word(hold_r[sel_idx_s]);
    end

    // Lane holding registers, pending bits, output register and frame counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r   <= '0;
            for (int i = 0; i < N; i++) begin
                hold_r[i] <= '0;
            end
            out_data_r  <= '0;
            out_idx_r   <= '0;
            out_last_r  <= 1'b0;
            out_valid_r <= 1'b0;
            overflow_r  <= 1'b0;
            frame_cnt_r <= '0;
        end else begin
            pending_r <= pending_nxt_s;
            for (int i = 0; i < N; i++) begin
                if (capture_s[i]) begin
                    hold_r[i] <= in_r[i*WW +: WW];
                end
            end
            if (load_s) begin
                out_data_r <= load_word_s;
                out_idx_r  <= sel_idx_s;
                out_last_r <= (cnt_eff_s == LAST_CNT);
            end
            out_valid_r <= out_valid_nxt_s;
            frame_cnt_r <= cnt_eff_s;
            if (|collide_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Activity FSM. It stays in STREAM while anything is pending or held.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (|capture_s) begin
                        state_r <= ST_STREAM;
                        busy_r  <= 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (!(|pending_nxt_s) && !out_valid_nxt_s) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign out_data  = out_data_r;
    assign out_idx   = out_idx_r;
    assign out_last  = out_last_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_pe_result_drain.sv
// -----------------------------------------------------------------------------
// tb_pe_result_drain
//
// Directed bench for pe_result_drain (N=4, OUTWIDTH=32). It covers the skewed
// column, simultaneous capture, backpressure, collision, reset mid-frame and
// the width/clamp rule. Outputs are sampled 1 time unit after the rising edge.
// Inputs change at the same point.
// -----------------------------------------------------------------------------
module tb_pe_result_drain;

    localparam int N  = 4;
    localparam int OW = 32;
    localparam int WW = OW + 1;

    logic               clk;
    logic               rst;
    logic [N*WW-1:0]    in_r;
    logic [N-1:0]       in_valid;
    logic [WW-1:0]      out_data;
    logic [1:0]         out_idx;
    logic               out_last;
    logic               out_valid;
    logic               out_ready;
    logic               busy;
    logic               overflow;

    int n_vec;
    int n_err;

    pe_result_drain #(.N(N), .OUTWIDTH(OW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_r      (in_r),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [63:0] d, input logic [63:0] idx,
                            input logic [63:0] last);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_data"},  64'(out_data),  d);
        chk({tag, "_idx"},   64'(out_idx),   idx);
        chk({tag, "_last"},  64'(out_last),  last);
    endtask

    task automatic set_lane(input int i, input logic [WW-1:0] v);
        in_r[i*WW +: WW] = v;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        in_r      = '0;
        in_valid  = '0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_valid",    64'(out_valid), 64'd0);
        chk("rst_data",     64'(out_data),  64'd0);
        chk("rst_idx",      64'(out_idx),   64'd0);
        chk("rst_last",     64'(out_last),  64'd0);
        chk("rst_busy",     64'(busy),      64'd0);
        chk("rst_overflow", 64'(overflow),  64'd0);
        rst = 1'b0;

        // ---- skewed column, out_ready=1 ----
        set_lane(0, 33'd10); in_valid = 4'b0001; tick();
        chk("sk_lat_valid", 64'(out_valid), 64'd0);
        chk("sk_busy",      64'(busy),      64'd1);
        set_lane(1, 33'd20); in_valid = 4'b0010; tick();
        chk_word("sk_w0", 64'd10, 64'd0, 64'd0);
        set_lane(2, 33'd30); in_valid = 4'b0100; tick();
        chk_word("sk_w1", 64'd20, 64'd1, 64'd0);
        set_lane(3, 33'd40); in_valid = 4'b1000; tick();
        chk_word("sk_w2", 64'd30, 64'd2, 64'd0);
        in_valid = 4'b0000; tick();
        chk_word("sk_w3", 64'd40, 64'd3, 64'd1);
        tick();
        chk("sk_end_valid", 64'(out_valid), 64'd0);
        chk("sk_end_busy",  64'(busy),      64'd0);
        chk("sk_overflow",  64'(overflow),  64'd0);

        // ---- simultaneous capture ----
        set_lane(0, 33'd5); set_lane(1, 33'd6); set_lane(2, 33'd7); set_lane(3, 33'd8);
        in_valid = 4'b1111; tick();
        chk("sim_lat_valid", 64'(out_valid), 64'd0);
        in_valid = 4'b0000; tick();
        chk_word("sim_w0", 64'd5, 64'd0, 64'd0);
        tick();
        chk_word("sim_w1", 64'd6, 64'd1, 64'd0);
        tick();
        chk_word("sim_w2", 64'd7, 64'd2, 64'd0);
        tick();
        chk_word("sim_w3", 64'd8, 64'd3, 64'd1);
        chk("sim_busy_hold", 64'(busy), 64'd1);
        tick();
        chk("sim_end_valid", 64'(out_valid), 64'd0);
        chk("sim_end_busy",  64'(busy),      64'd0);

        // ---- backpressure ----
        out_ready = 1'b0;
        set_lane(0, 33'd10); in_valid = 4'b0001; tick();
        set_lane(1, 33'd20); in_valid = 4'b0010; tick();
        chk_word("bp_s0", 64'd10, 64'd0, 64'd0);
        set_lane(2, 33'd30); in_valid = 4'b0100; tick();
        chk_word("bp_s1", 64'd10, 64'd0, 64'd0);
        set_lane(3, 33'd40); in_valid = 4'b1000; tick();
        chk_word("bp_s2", 64'd10, 64'd0, 64'd0);
        in_valid = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_word("bp_stall", 64'd10, 64'd0, 64'd0);
        end
        out_ready = 1'b1; tick();
        chk_word("bp_w1", 64'd20, 64'd1, 64'd0);
        tick();
        chk_word("bp_w2", 64'd30, 64'd2, 64'd0);
        tick();
        chk_word("bp_w3", 64'd40, 64'd3, 64'd1);
        tick();
        chk("bp_end_valid", 64'(out_valid), 64'd0);
        chk("bp_overflow",  64'(overflow),  64'd0);

        // ---- collision: output register occupied, lane 1 pulses twice ----
        out_ready = 1'b0;
        set_lane(0, 33'h0AA); in_valid = 4'b0001; tick();
        set_lane(1, 33'h011); in_valid = 4'b0010; tick();
        chk_word("col_w0", 64'h0AA, 64'd0, 64'd0);
        chk("col_pre_ovf", 64'(overflow), 64'd0);
        set_lane(1, 33'h022); in_valid = 4'b0010; tick();
        chk("col_ovf", 64'(overflow), 64'd1);
        in_valid = 4'b0000; tick();
        chk("col_ovf_sticky", 64'(overflow), 64'd1);
        out_ready = 1'b1; tick();
        chk_word("col_w1", 64'h011, 64'd1, 64'd0);
        tick();
        chk("col_end_valid", 64'(out_valid), 64'd0);
        chk("col_ovf_sticky2", 64'(overflow), 64'd1);

        // ---- reset mid-frame ----
        rst = 1'b1; tick(); rst = 1'b0;
        set_lane(0, 33'd1); set_lane(1, 33'd2); set_lane(2, 33'd3); set_lane(3, 33'd4);
        in_valid = 4'b1111; tick();
        set_lane(3, 33'h99); in_valid = 4'b1000; tick();   // lane 3 still pending -> lost
        chk_word("rm_w0", 64'd1, 64'd0, 64'd0);
        chk("rm_ovf", 64'(overflow), 64'd1);
        in_valid = 4'b0000; tick();
        chk_word("rm_w1", 64'd2, 64'd1, 64'd0);
        tick();
        chk_word("rm_w2", 64'd3, 64'd2, 64'd0);
        rst = 1'b1; set_lane(0, 33'h55); in_valid = 4'b0001; tick();
        rst = 1'b0; in_valid = 4'b0000;
        chk("rm_valid", 64'(out_valid), 64'd0);
        chk("rm_busy",  64'(busy),      64'd0);
        chk("rm_ovf0",  64'(overflow),  64'd0);
        chk("rm_data",  64'(out_data),  64'd0);
        tick();
        chk("rm_discard_valid", 64'(out_valid), 64'd0);
        chk("rm_discard_busy",  64'(busy),      64'd0);
        set_lane(0, 33'h101); in_valid = 4'b0001; tick();
        set_lane(1, 33'h102); in_valid = 4'b0010; tick();
        chk_word("rm_n0", 64'h101, 64'd0, 64'd0);
        set_lane(2, 33'h103); in_valid = 4'b0100; tick();
        chk_word("rm_n1", 64'h102, 64'd1, 64'd0);
        set_lane(3, 33'h104); in_valid = 4'b1000; tick();
        chk_word("rm_n2", 64'h103, 64'd2, 64'd0);
        in_valid = 4'b0000; tick();
        chk_word("rm_n3", 64'h104, 64'd3, 64'd1);
        tick();

        // ---- width rule / clamp ----
        set_lane(0, 33'h1_0000_0005); in_valid = 4'b0001; tick();
        set_lane(1, 33'h7); in_valid = 4'b0010; tick();
`ifdef PE_DRAIN_SAT_EN
        chk_word("wd_big", 64'h0_FFFF_FFFF, 64'd0, 64'd0);
`else
        chk_word("wd_big", 64'h1_0000_0005, 64'd0, 64'd0);
`endif
        in_valid = 4'b0000; tick();
        chk_word("wd_small", 64'h7, 64'd1, 64'd0);
        tick();
        chk("wd_end_valid", 64'(out_valid), 64'd0);
        chk("wd_overflow",  64'(overflow),  64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pe_result_drain.md
Name: pe_result_drain

Overview:
- Collects accumulated results from one column of N PE cells and serialises them onto a single valid/ready stream.
- Each PE raises a one-cycle result-valid pulse when its fire window ends. The pulses arrive skewed, one cycle apart, down the column.
- The block holds each lane's result until the downstream consumer (output buffer or DMA writer) accepts it. This lets the array keep firing without a stall path back into the PEs.

Parameters:
- N, 4, number of PE lanes (rows) in the column; N >= 2.
- OUTWIDTH, 32, PE accumulator width parameter; result words are OUTWIDTH+1 bits.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_r  input  N*(OUTWIDTH+1)  flattened PE results; lane i occupies bits [i*(OUTWIDTH+1) +: OUTWIDTH+1].
- in_valid  input  N  per-lane result-valid pulse; lane i is sampled together with its in_r slice.
- out_data  output  OUTWIDTH+1  result word presented downstream.
- out_idx  output  $clog2(N)  lane index of out_data.
- out_last  output  1  high with the Nth word of a frame.
- out_valid  output  1  out_data, out_idx and out_last are valid.
- out_ready  input  1  downstream accepts the word when out_valid && out_ready.
- busy  output  1  any lane pending or out_valid high.
- overflow  output  1  sticky: a result was lost.

Behaviour:
- Reset (rst=1 at an edge):
  - Outputs: out_valid=0, out_data=0, out_idx=0, out_last=0, overflow=0, busy=0.
  - Internal state: all pending bits and holding registers cleared, frame counter=0, FSM=IDLE.
  - Reset mid-stream discards all held and in-flight results; no partial frame survives.
- Capture:
  - in_valid[i]=1 at an edge with pending[i]=0: hold[i] <= in_r slice i and pending[i] <= 1.
  - Capture is independent per lane; any subset of lanes may capture in the same cycle.
- Collision: in_valid[i]=1 while pending[i]=1 and lane i is not being moved into the output register that cycle.
  - The new value is dropped and the old value is kept.
  - overflow <= 1, and it stays 1 until reset.
- Simultaneous move and capture on the same lane: the new value is accepted, pending stays 1, no overflow.
- Output register load:
  - Condition: (!out_valid || out_ready) and some pending bit is set.
  - Selection: the lowest-index pending lane j.
  - Loads: out_data <= hold[j], out_idx <= j, pending[j] <= 0, out_valid <= 1.
  - If nothing is pending and out_ready=1, out_valid <= 0.
- Latency: in_valid[i] at edge t gives out_valid=1 after edge t+1 (2-cycle minimum, including the capture edge).
- Throughput: one word per cycle with out_ready held high.
- Stream stability: while out_valid=1 and out_ready=0, out_data, out_idx and out_last hold stable.
- Frame counter: counts accepted words (out_valid && out_ready) modulo N.
  - out_last=1 on the loaded word iff the counter equals N-1 at load time, accounting for an acceptance in the same cycle.
  - The counter wraps to 0 after the last word is accepted.
- FSM:
  - IDLE: no pending, out_valid=0.
  - STREAM: word held or pending.
  - IDLE->STREAM on any capture; STREAM->IDLE when the last pending word is accepted and no capture occurs that cycle.
  - busy = (state==STREAM).
- Width rule: result words pass through unmodified; no arithmetic on data (except the optional clamp below).

Optional Feature:
- Macro: PE_DRAIN_SAT_EN.
- Defined: at output-register load, any word with bit OUTWIDTH set is clamped to 2^OUTWIDTH-1, so out_data[OUTWIDTH] is always 0. Words below the threshold pass unchanged.
- Not defined: all OUTWIDTH+1 bits pass through unmodified.
- Latency and handshake are identical in both builds.

Test Plan:
- Skewed column, N=4, out_ready=1: in_valid lanes 0..3 pulse on consecutive cycles with values 10, 20, 30, 40.
  - Required: out_valid words 10, 20, 30, 40 with idx 0..3 on consecutive cycles.
  - First word appears 2 cycles after lane 0's pulse; out_last only on 40; overflow=0.
- Simultaneous capture: all four lanes pulse in one cycle (5, 6, 7, 8), out_ready=1.
  - Required: words 5, 6, 7, 8 in lane order on 4 consecutive cycles; busy falls after 8 is accepted.
- Backpressure: repeat the skewed case with out_ready=0 for 6 cycles, then 1.
  - Required: out_data=10 and idx=0 stable throughout the stall.
  - Then 20, 30, 40 follow back-to-back; no loss; overflow=0.
- Collision: lane 1 captures 0x11, out_ready=0, then lane 1 pulses 0x22.
  - Required: overflow=1 (sticky) and the emitted lane-1 word is 0x11.
- Reset mid-frame: after 2 of 4 words are accepted, assert rst for 1 cycle.
  - Required: out_valid=0, busy=0, overflow=0.
  - A new frame then emits out_last on its 4th word, not its 2nd.
- PE_DRAIN_SAT_EN, OUTWIDTH=32: lane 0 value 0x1_0000_0005 -> out_data=0x0_FFFF_FFFF. Lane 1 value 0x7 -> 0x7.
  - Without the macro: 0x1_0000_0005 passes unchanged.
